decode_sequencer: RTL and testbench

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

---
 rtl/decode_sequencer.sv | 119 +++++++++++
 tb/tb_decode_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_sequencer.sv
// Splits 64-bit fetch words into two 32-bit instructions for the decoder, halting on a zero instruction.
// Optional retired-instruction counter enabled by `define DECODE_SEQ_INSTR_COUNT_EN.
module decode_sequencer #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH     = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BUS_DATA_WIDTH-1:0]   in_word,
    input  logic [ADDR_WIDTH-1:0]       in_pc,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BUS_DATA_WIDTH/2-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]       out_pc,
    output logic                        halted,
    output logic [31:0]                 instr_count
);

    localparam int IW = BUS_DATA_WIDTH / 2;

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_HALT} state_t;

    state_t                      r_state, w_next;
    logic [BUS_DATA_WIDTH-1:0]   r_buf;
    logic [ADDR_WIDTH-1:0]       r_buf_pc;
    logic [IW-1:0]               w_instr;
    logic                        w_zero;
    logic                        w_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_buf    <= '0;
            r_buf_pc <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_buf    <= in_word;
                r_buf_pc <= in_pc;
            end
        end
    end

    always_comb begin
        w_instr   = (r_state == S_HIGH) ? r_buf[BUS_DATA_WIDTH-1:IW] : r_buf[IW-1:0];
        w_zero    = (w_instr == '0);
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load = 1'b1;
                    w_next = in_pc[2] ? S_HIGH : S_LOW;
                end
            end
            S_LOW: begin
                if (w_zero) begin
                    w_next = S_HALT;
                end else begin
                    out_valid = 1'b1;
                    if (out_ready) w_next = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_zero) begin
                    w_next = S_HALT;
                end else begin
                    out_valid = 1'b1;
                    // Refill while the upper half drains so consecutive words stream without a bubble.
                    in_ready  = out_ready;
                    if (out_ready) begin
                        if (in_valid) begin
                            w_load = 1'b1;
                            w_next = in_pc[2] ? S_HIGH : S_LOW;
                        end else begin
                            w_next = S_IDLE;
                        end
                    end
                end
            end
            default: w_next = S_HALT;
        endcase
        if (flush) begin
            w_next    = S_IDLE;
            in_ready  = 1'b0;
            out_valid = 1'b0;
            w_load    = 1'b0;
        end
    end

    assign out_instr = w_instr;
    assign out_pc    = (r_state == S_HIGH) ? {r_buf_pc[ADDR_WIDTH-1:3], 3'b100} : r_buf_pc;
    assign halted    = (r_state == S_HALT);

`ifdef DECODE_SEQ_INSTR_COUNT_EN
    logic [31:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (out_valid && out_ready) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign instr_count = r_count;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench for decode_sequencer: expected instructions are queued when a word is
// offered and retired against every out_valid&&out_ready handshake.
module tb_decode_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_word;
    logic [63:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        halted;
    logic [31:0] instr_count;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   hs_cnt   = 0;

`ifdef DECODE_SEQ_INSTR_COUNT_EN
    localparam logic [31:0] EXP_CNT_BASIC = 32'd2;
`else
    localparam logic [31:0] EXP_CNT_BASIC = 32'd0;
`endif

    decode_sequencer #(.BUS_DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Retire one expected entry per handshake; a handshake with nothing expected is an error.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            hs_cnt++;
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got %h@%h, expected none", out_instr, out_pc);
            end else begin
                e = sb_q.pop_front();
                if (out_instr !== e.instr || out_pc !== e.pc)
                    $display("FAIL sb_data: got %h@%h, expected %h@%h", out_instr, out_pc, e.instr, e.pc);
                else n_pass++;
            end
        end
    end

    task automatic send_word(input logic [63:0] w, input logic [63:0] pc);
        bit acc = 1'b0;
        logic [31:0] lo, hi;
        lo = w[31:0];
        hi = w[63:32];
        in_valid = 1'b1; in_word = w; in_pc = pc;
        if (!pc[2] && lo != 32'h0) sb_q.push_back(exp_t'{lo, pc});
        if ((pc[2] || lo != 32'h0) && hi != 32'h0) sb_q.push_back(exp_t'{hi, {pc[63:3], 3'b100}});
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        n_checks++;
        if (!acc) $display("FAIL send_timeout: pc %h not accepted, expected accept", pc);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_word = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, expected 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b, expected 1", in_ready); else n_pass++;
        n_checks++; if (out_instr !== 32'h0) $display("FAIL rst_out_instr: got %h, expected 0", out_instr); else n_pass++;
        n_checks++; if (out_pc !== 64'h0) $display("FAIL rst_out_pc: got %h, expected 0", out_pc); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b, expected 0", halted); else n_pass++;
        n_checks++; if (instr_count !== 32'h0) $display("FAIL rst_count: got %h, expected 0", instr_count); else n_pass++;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_word(64'h00A00093_00500113, 64'h1000);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_latency: got %b, expected 1", out_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_second: got %b, expected 1", out_valid); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL basic_idle: got valid=%b ready=%b, expected 0/1", out_valid, in_ready); else n_pass++;
        n_checks++; if (instr_count !== EXP_CNT_BASIC)
            $display("FAIL basic_count: got %0d, expected %0d", instr_count, EXP_CNT_BASIC); else n_pass++;
        n_checks++; if (sb_q.size() != 0) $display("FAIL basic_drain: got %0d pending, expected 0", sb_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int base;
        @(posedge clk); #1;
        out_ready = 1'b1;
        base = hs_cnt;
        send_word(64'h00300193_00200113, 64'h1000);
        send_word(64'h00500293_00400213, 64'h1008);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++; if (hs_cnt != base + 4) $display("FAIL b2b_nobubble: got %0d handshakes, expected %0d", hs_cnt - base, 4); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_idle: got %b, expected 0", out_valid); else n_pass++;
        n_checks++; if (sb_q.size() != 0) $display("FAIL b2b_drain: got %0d pending, expected 0", sb_q.size()); else n_pass++;
    endtask

    task automatic test_single_high();
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_word(64'h00000013_DEADBEEF, 64'h2004);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h2004)
            $display("FAIL high_out: got valid=%b pc=%h, expected 1/2004", out_valid, out_pc); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL high_idle: got valid=%b ready=%b, expected 0/1", out_valid, in_ready); else n_pass++;
        n_checks++; if (sb_q.size() != 0) $display("FAIL high_drain: got %0d pending, expected 0", sb_q.size()); else n_pass++;
    endtask

    task automatic test_halt();
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_word(64'h00000013_00000000, 64'h3000);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL halt_novalid: got %b, expected 0", out_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (halted !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL halt_state: got halted=%b ready=%b valid=%b, expected 1/0/0", halted, in_ready, out_valid); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b1; in_word = 64'h00700393_00600313; in_pc = 64'h3100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b0 || halted !== 1'b1)
                $display("FAIL halt_sticky: got ready=%b halted=%b, expected 0/1", in_ready, halted); else n_pass++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL halt_flush_cycle: got ready=%b valid=%b, expected 0/0", in_ready, out_valid); else n_pass++;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        n_checks++; if (halted !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL halt_release: got halted=%b ready=%b valid=%b, expected 0/1/0", halted, in_ready, out_valid); else n_pass++;
    endtask

    task automatic test_stall_flush();
        logic [31:0] s_instr;
        logic [63:0] s_pc;
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_word(64'h00200113_00100093, 64'h4000);
        in_valid = 1'b0;
        @(negedge clk);
        s_instr = out_instr; s_pc = out_pc;
        n_checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00100093 || out_pc !== 64'h4000)
            $display("FAIL stall_first: got %b %h@%h, expected 1 00100093@4000", out_valid, out_instr, out_pc); else n_pass++;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        n_checks++; if (out_instr !== s_instr || out_pc !== s_pc)
            $display("FAIL stall_stable: got %h@%h, expected %h@%h", out_instr, out_pc, s_instr, s_pc); else n_pass++;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL stall_flush_cycle: got valid=%b ready=%b, expected 0/0", out_valid, in_ready); else n_pass++;
        @(posedge clk); #1;
        flush = 1'b0;
        sb_q.delete();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_count !== 32'h0)
            $display("FAIL stall_idle: got valid=%b ready=%b cnt=%0d, expected 0/1/0", out_valid, in_ready, instr_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_word(64'h00000022_00000011, 64'h5000);
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rstmid_hs: got valid=%b ready=%b, expected 0/1", out_valid, in_ready); else n_pass++;
        n_checks++; if (out_instr !== 32'h0 || out_pc !== 64'h0 || instr_count !== 32'h0 || halted !== 1'b0)
            $display("FAIL rstmid_vals: got %h@%h cnt=%0d halted=%b, expected 0@0 0 0", out_instr, out_pc, instr_count, halted); else n_pass++;
        sb_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL rstmid_after: got valid=%b ready=%b, expected 0/1", out_valid, in_ready); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_single_high();
        test_halt();
        test_stall_flush();
        test_reset_mid();
        n_checks++; if (sb_q.size() != 0) $display("FAIL final_drain: got %0d pending, expected 0", sb_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
